icache_sa: RTL
==============

# icache_sa

Parametrised set-associative instruction cache with multi-word lines, burst refill, true-LRU replacement, whole-cache flush and hit/miss counters. It sits between the fetch stage and the instruction memory port and replaces the single-word, fixed-geometry instruction cache. All responses are registered, and misses are serviced by a line-aligned burst of `WORDS_PER_LINE` beats.

## Interface
- `NUM_SETS`, default 64: sets; power of two, at least 2.
- `NUM_WAYS`, default 4: ways per set; power of two, 2 to 8.
- `WORDS_PER_LINE`, default 4: 32-bit words per line; power of two, at least 1.
- Derived widths:
  - `OFF_W = log2(WORDS_PER_LINE) + 2`
  - `IDX_W = log2(NUM_SETS)`
  - `TAG_W = 32 - IDX_W - OFF_W`
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low.
- `req_valid`  in  1  fetch request.
- `req_addr`  in  32  fetch byte address; bits [1:0] ignored.
- `req_ready`  out  1  high only in IDLE with no flush pending.
- `resp_valid`  out  1  one-cycle pulse returning the fetched word.
- `resp_data`  out  32  fetched instruction word.
- `flush`  in  1  one-cycle request to invalidate all lines.
- `mem_req_valid`  out  1  line refill request.
- `mem_req_ready`  in  1  memory accepts the refill request.
- `mem_req_addr`  out  32  line-aligned address; low `OFF_W` bits are zero.
- `mem_resp_valid`  in  1  refill beat valid.
- `mem_resp_data`  in  32  refill beat data; beats arrive in word order 0..`WORDS_PER_LINE`-1.
- `hit_count`  out  32  lookups that hit; wraps modulo 2^32.
- `miss_count`  out  32  lookups that missed; wraps modulo 2^32.

## Operation
- Address split: tag = [31:`IDX_W`+`OFF_W`], index = [`IDX_W`+`OFF_W`-1:`OFF_W`], word = [`OFF_W`-1:2].
- Storage:
  - Per way/set: a tag, a valid bit and `WORDS_PER_LINE` data words.
  - Per way/set: an LRU age of log2(`NUM_WAYS`) bits. Ages within a set always form a permutation of 0..`NUM_WAYS`-1; 0 is most recent.
- States: IDLE, LOOKUP, MEM_REQ, REFILL, RESP, FLUSH.
- IDLE:
  - If a flush is pending, go to FLUSH.
  - Otherwise, `req_valid && req_ready` latches the address and moves to LOOKUP.
- LOOKUP: compare the tag across all ways of the set.
  - Hit: increment `hit_count`, latch the word, update LRU for the hit way, go to RESP.
  - Miss: increment `miss_count`, choose a victim, go to MEM_REQ.
- Victim selection: the lowest-indexed invalid way; if every way is valid, the way with age `NUM_WAYS`-1.
- MEM_REQ: hold `mem_req_valid` = 1 and `mem_req_addr` stable until `mem_req_ready`; then go to REFILL with the beat counter at 0.
- REFILL:
  - Each `mem_resp_valid` writes beat k into word k of the victim line and captures it if k equals the requested word.
  - On the last beat: write the tag, set valid, update LRU for the victim, go to RESP.
- LRU update for way u: every way whose age is below age(u) increments by 1; age(u) becomes 0.
- RESP: `resp_valid` = 1 for exactly one cycle with `resp_data` = the requested word; then go to IDLE.
- FLUSH:
  - Clears the valid bits of one set per cycle, index 0 to `NUM_SETS`-1, and resets that set's ages to way i = i.
  - Lasts `NUM_SETS` cycles, then goes to IDLE and clears the pending flag.
- Flush pending flag: a `flush` pulse in any state sets it. A flush arriving during LOOKUP/MEM_REQ/REFILL/RESP lets the current request finish first.
- Flush vs request in IDLE: when both a pending flush and `req_valid` are present, the flush wins.
- Ignored memory beats: `mem_resp_valid` outside REFILL is ignored, and so are beats beyond `WORDS_PER_LINE`.
- Reset values:
  - State IDLE; all valid bits 0; ages way i = i; both counters 0; flush pending 0.
  - `req_ready` = 1, `resp_valid` = 0, `resp_data` = 0, `mem_req_valid` = 0, `mem_req_addr` = 0.
  - Tag and data arrays are not reset.
- Reset mid-operation: an in-flight refill is abandoned and the line is never marked valid. Any later beats from memory are ignored in IDLE.

## Timing
- Hit latency: request accepted at edge N, LOOKUP during cycle N+1, `resp_valid` high during cycle N+2.
- Back-to-back requests: `req_ready` is high again in cycle N+3, giving one request per 3 cycles.
- Miss latency: 3 cycles + memory request wait + `WORDS_PER_LINE` beat cycles + 1 cycle in RESP.
- `mem_req_valid` rises in the cycle after LOOKUP and drops the cycle after the `mem_req_ready` handshake.
- `hit_count` and `miss_count` update at the edge ending LOOKUP.
- `req_ready` is 0 in every state except IDLE, and is also 0 in IDLE whenever a flush is pending.
- Flush blocks requests for `NUM_SETS` + 1 cycles from the `flush` pulse when issued in IDLE.

## Test plan
- Cold miss:
  - Stimulus: defaults, read 0x0000_0108; memory returns beats 0xA0..0xA3.
  - Response: `mem_req_addr` = 0x100; `resp_data` = 0xA2 one cycle after the last beat; `miss_count` = 1.
- Hit timing:
  - Stimulus: after the cold miss, read 0x10C.
  - Response: no memory request; `resp_data` = 0xA3 in cycle N+2; `hit_count` = 1.
- LRU eviction:
  - Stimulus: fill set 0 with 0x000, 0x400, 0x800, 0xC00; re-read 0x000; then read 0x1000.
  - Response: the line at 0x400 is evicted, so a read of 0x400 misses while 0x000 hits.
- Memory backpressure:
  - Stimulus: hold `mem_req_ready` = 0 for 5 cycles; insert 2 gap cycles between beats.
  - Response: address held stable throughout, `mem_req_valid` stays high, the correct word is returned, and no spurious `resp_valid`.
- Flush during refill:
  - Stimulus: pulse `flush` during beat 1 of a refill.
  - Response: the refill completes and responds, then 64 FLUSH cycles follow, then a read of the same address misses.
- Reset mid-refill:
  - Stimulus: assert `reset` after beat 2, then release it.
  - Response: all outputs at reset values, trailing beats ignored, and the next read of that line misses.

Source files
------------

// File: rtl/icache_sa.sv
// Set-associative instruction cache: multi-word lines, burst refill from a
// line-aligned memory request, true-LRU replacement, whole-cache flush, hit/miss counters.
module icache_sa #(
  parameter int unsigned NUM_SETS       = 64,
  parameter int unsigned NUM_WAYS       = 4,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  input  logic        flush,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int unsigned WORD_W = $clog2(WORDS_PER_LINE);
  localparam int unsigned WSEL_W = (WORD_W > 0) ? WORD_W : 1;
  localparam int unsigned OFF_W  = WORD_W + 2;
  localparam int unsigned IDX_W  = $clog2(NUM_SETS);
  localparam int unsigned TAG_W  = 32 - IDX_W - OFF_W;
  localparam int unsigned WAY_W  = $clog2(NUM_WAYS);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MEM_REQ, S_REFILL, S_RESP, S_FLUSH
  } state_t;

  typedef logic [NUM_WAYS-1:0][WAY_W-1:0] ages_t;

  state_t              state;
  logic [TAG_W-1:0]    lat_tag;
  logic [IDX_W-1:0]    lat_idx;
  logic [WSEL_W-1:0]   lat_word;
  logic [WSEL_W-1:0]   beat;
  logic [WAY_W-1:0]    victim;
  logic [31:0]         fill_word;
  logic                flush_pend;
  logic [IDX_W-1:0]    flush_idx;

  logic [NUM_WAYS-1:0] valid_q  [NUM_SETS];
  ages_t               age_q    [NUM_SETS];
  logic [TAG_W-1:0]    tag_mem  [NUM_SETS][NUM_WAYS];
  logic [31:0]         data_mem [NUM_SETS][NUM_WAYS][WORDS_PER_LINE];

  logic                hit;
  logic [WAY_W-1:0]    hit_way;
  logic [WAY_W-1:0]    evict_way;
  logic                found_invalid;
  logic [31:0]         hit_word;
  logic                fill_we;
  logic                fill_last;

  // Byte-offset bits of the fetch address carry no information for word fetches.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[1:0];

  function automatic logic [WSEL_W-1:0] word_of(input logic [31:0] addr);
    return (WORDS_PER_LINE == 1) ? '0 : WSEL_W'(addr >> 2);
  endfunction

  function automatic ages_t init_ages();
    ages_t r;
    for (int w = 0; w < NUM_WAYS; w++) r[w] = WAY_W'(w);
    return r;
  endfunction

  // Make way u most recent; ways that were more recent than u age by one.
  function automatic ages_t touch(input ages_t ages, input logic [WAY_W-1:0] u);
    ages_t r;
    r = ages;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (ages[w] < ages[u]) r[w] = ages[w] + WAY_W'(1);
    end
    r[u] = '0;
    return r;
  endfunction

  // Tag compare and victim choice for the latched set.
  always_comb begin
    hit           = 1'b0;
    hit_way       = '0;
    evict_way     = '0;
    found_invalid = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!hit && valid_q[lat_idx][w] && (tag_mem[lat_idx][w] == lat_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (age_q[lat_idx][w] == WAY_W'(NUM_WAYS - 1)) evict_way = WAY_W'(w);
    end
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!found_invalid && !valid_q[lat_idx][w]) begin
        found_invalid = 1'b1;
        evict_way     = WAY_W'(w);
      end
    end
  end

  assign hit_word  = data_mem[lat_idx][hit_way][lat_word];
  assign fill_we   = (state == S_REFILL) && mem_resp_valid;
  assign fill_last = (beat == WSEL_W'(WORDS_PER_LINE - 1));

  // Tag and data storage are plain RAM contents and carry no reset.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_mem[lat_idx][victim][beat] <= mem_resp_data;
      if (fill_last) tag_mem[lat_idx][victim] <= lat_tag;
    end
  end

  // Control FSM with valid/age state, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      lat_tag       <= '0;
      lat_idx       <= '0;
      lat_word      <= '0;
      beat          <= '0;
      victim        <= '0;
      fill_word     <= '0;
      flush_pend    <= 1'b0;
      flush_idx     <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        age_q[s]   <= init_ages();
      end
      hit_count     <= '0;
      miss_count    <= '0;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_data     <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
    end else begin
      if (flush) flush_pend <= 1'b1;
      case (state)
        S_IDLE: begin
          if (flush_pend) begin
            state     <= S_FLUSH;
            flush_idx <= '0;
            req_ready <= 1'b0;
          end else if (req_valid && req_ready && !flush) begin
            lat_tag   <= req_addr[OFF_W+IDX_W +: TAG_W];
            lat_idx   <= req_addr[OFF_W +: IDX_W];
            lat_word  <= word_of(req_addr);
            state     <= S_LOOKUP;
            req_ready <= 1'b0;
          end else if (flush) begin
            req_ready <= 1'b0;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            hit_count      <= hit_count + 32'd1;
            resp_data      <= hit_word;
            resp_valid     <= 1'b1;
            age_q[lat_idx] <= touch(age_q[lat_idx], hit_way);
            state          <= S_RESP;
          end else begin
            miss_count    <= miss_count + 32'd1;
            victim        <= evict_way;
            mem_req_valid <= 1'b1;
            mem_req_addr  <= {lat_tag, lat_idx, {OFF_W{1'b0}}};
            state         <= S_MEM_REQ;
          end
        end
        S_MEM_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            beat          <= '0;
            state         <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (mem_resp_valid) begin
            if (beat == lat_word) fill_word <= mem_resp_data;
            beat <= beat + WSEL_W'(1);
            if (fill_last) begin
              valid_q[lat_idx][victim] <= 1'b1;
              age_q[lat_idx]           <= touch(age_q[lat_idx], victim);
              resp_data                <= (beat == lat_word) ? mem_resp_data : fill_word;
              resp_valid               <= 1'b1;
              state                    <= S_RESP;
            end
          end
        end
        S_RESP: begin
          resp_valid <= 1'b0;
          state      <= S_IDLE;
          req_ready  <= !(flush_pend || flush);
        end
        S_FLUSH: begin
          valid_q[flush_idx] <= '0;
          age_q[flush_idx]   <= init_ages();
          if (flush_idx == IDX_W'(NUM_SETS - 1)) begin
            // A flush pulse landing on the final sweep cycle schedules another sweep.
            flush_pend <= flush;
            req_ready  <= !flush;
            state      <= S_IDLE;
          end else begin
            flush_idx <= flush_idx + IDX_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
